// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble size, FSM states and
// the counter-width helper.
package adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count WIDTH/NIBBLE nibbles, never less than one.
  function automatic int cnt_width(input int width);
    int n_nib;
    n_nib = width / NIBBLE;
    return (n_nib > 1) ? $clog2(n_nib) : 1;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry look-ahead slice: every carry is formed directly
// from generate/propagate terms and ci, with no ripple between bit positions.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;
  logic       w_c4;

  assign w_g = a & b;
  assign w_p = a | b;

  assign w_c1 = w_g[0] | (w_p[0] & ci);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = a ^ b ^ {w_c3, w_c2, w_c1, ci};
  assign co = w_c4;

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: streams one nibble pair per cycle, LSB first,
// through a 4-bit CLA slice and carries between nibbles in a register.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy
);

  import adder_pkg::*;

  localparam int               NNIB     = WIDTH / NIBBLE;
  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NNIB - 1);

  generate
    if (((WIDTH % NIBBLE) != 0) || (WIDTH < NIBBLE)) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic [3:0]       w_slice_s;
  logic             w_slice_co;
  logic [WIDTH-1:0] w_sum_next;

  cla4_slice u_cla4_slice (
    .a  (r_a_sh[3:0]),
    .b  (r_b_sh[3:0]),
    .ci (r_carry),
    .s  (w_slice_s),
    .co (w_slice_co)
  );

  // New slice nibble enters at the top so the LSB nibble ends up at bit 0.
  generate
    if (WIDTH == NIBBLE) begin : g_sum_single
      assign w_sum_next = w_slice_s;
    end else begin : g_sum_shift
      assign w_sum_next = {w_slice_s, r_sum[WIDTH-1:NIBBLE]};
    end
  endgenerate

  // Control FSM together with the datapath registers it sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= {WIDTH{1'b0}};
      r_b_sh      <= {WIDTH{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_s         <= {WIDTH{1'b0}};
      r_co        <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_carry    <= ci;
            r_cnt      <= {CNT_W{1'b0}};
            r_state    <= ADD;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        ADD: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_co;
          r_a_sh  <= r_a_sh >> NIBBLE;
          r_b_sh  <= r_b_sh >> NIBBLE;
          // Published result changes only here, on entry to DONE.
          if (r_cnt == LAST_NIB) begin
            r_state     <= DONE;
            r_s         <= w_sum_next;
            r_co        <= w_slice_co;
            r_out_valid <= 1'b1;
            r_cnt       <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= {CNT_W{1'b0}};
          r_carry     <= 1'b0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign co        = r_co;
  assign busy      = r_busy;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH 16, 4 and 32: directed cases on the
// 16-bit instance plus randomized traffic against a cycle-level reference model.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_v   [3];
  logic [31:0] b_v   [3];
  logic        ci_v  [3];
  logic        iv_v  [3];
  logic        ordy_v[3];

  logic [31:0] s_v [3];
  logic        co_v[3];
  logic        ov_v[3];
  logic        ir_v[3];
  logic        bz_v[3];

  wire [15:0] s0;
  wire [3:0]  s1;
  wire [31:0] s2;
  wire co0, co1, co2, ov0, ov1, ov2, ir0, ir1, ir2, bz0, bz1, bz2;

  nibble_serial_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv_v[0]), .in_ready(ir0),
    .a(a_v[0][15:0]), .b(b_v[0][15:0]), .ci(ci_v[0]),
    .out_valid(ov0), .out_ready(ordy_v[0]), .s(s0), .co(co0), .busy(bz0)
  );

  nibble_serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv_v[1]), .in_ready(ir1),
    .a(a_v[1][3:0]), .b(b_v[1][3:0]), .ci(ci_v[1]),
    .out_valid(ov1), .out_ready(ordy_v[1]), .s(s1), .co(co1), .busy(bz1)
  );

  nibble_serial_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv_v[2]), .in_ready(ir2),
    .a(a_v[2]), .b(b_v[2]), .ci(ci_v[2]),
    .out_valid(ov2), .out_ready(ordy_v[2]), .s(s2), .co(co2), .busy(bz2)
  );

  always_comb begin
    s_v[0]  = {16'h0000, s0};
    s_v[1]  = {28'h0000000, s1};
    s_v[2]  = s2;
    co_v[0] = co0; co_v[1] = co1; co_v[2] = co2;
    ov_v[0] = ov0; ov_v[1] = ov1; ov_v[2] = ov2;
    ir_v[0] = ir0; ir_v[1] = ir1; ir_v[2] = ir2;
    bz_v[0] = bz0; bz_v[1] = bz1; bz_v[2] = bz2;
  end

  int total = 0;
  int bad   = 0;

  function automatic int wid(input int k);
    case (k)
      0:       return 16;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] msk(input int k);
    logic [32:0] full;
    full = (33'd1 << wid(k)) - 33'd1;
    return full[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted transaction completes L=WIDTH/4 edges later,
  // the result is {co,s} = a+b+ci, and it is held until out_ready releases it.
  bit          mv    [3];
  bit          pend  [3];
  int          cnt   [3];
  logic [32:0] res   [3];
  logic [32:0] exp_sc[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; pend[k] = 1'b0; cnt[k] = 0;
      res[k] = 33'd0; exp_sc[k] = 33'd0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int          lat;
      logic [31:0] m;
      logic [32:0] t;
      lat = wid(k) / 4;
      m   = msk(k);
      if (mv[k]) begin
        chk($sformatf("ctl_w%0d{ov,ir,busy}", wid(k)),
            {61'd0, ov_v[k], ir_v[k], bz_v[k]},
            {61'd0, (pend[k] && (cnt[k] == lat)), !pend[k], pend[k]});
        chk($sformatf("res_w%0d{co,s}", wid(k)),
            {31'd0, co_v[k], s_v[k]}, {31'd0, exp_sc[k]});
      end
      if (rst) begin
        mv[k]     = 1'b1;
        pend[k]   = 1'b0;
        cnt[k]    = 0;
        exp_sc[k] = 33'd0;
      end else if (mv[k]) begin
        if (!pend[k]) begin
          if (iv_v[k]) begin
            t       = {1'b0, a_v[k] & m} + {1'b0, b_v[k] & m} + 33'(ci_v[k]);
            res[k]  = {t[wid(k)], t[31:0] & m};
            pend[k] = 1'b1;
            cnt[k]  = 0;
          end
        end else if (cnt[k] == lat) begin
          if (ordy_v[k]) pend[k] = 1'b0;
        end else begin
          cnt[k] = cnt[k] + 1;
          if (cnt[k] == lat) exp_sc[k] = res[k];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic accept0(input logic [15:0] a, input logic [15:0] b, input logic ci);
    int n;
    n = 0;
    while (!ir_v[0] && n < 50) begin
      cyc();
      n++;
    end
    chk("accept_wait_in_ready", 64'(ir_v[0]), 64'd1);
    a_v[0]  = {16'h0000, a};
    b_v[0]  = {16'h0000, b};
    ci_v[0] = ci;
    iv_v[0] = 1'b1;
    cyc();
    iv_v[0] = 1'b0;
  endtask

  task automatic wait_ov0(output int e);
    e = 0;
    while (!ov_v[0] && e < 40) begin
      cyc();
      e++;
    end
  endtask

  task automatic run0(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] exp_s, input logic exp_co, input string nm);
    int e;
    accept0(a, b, ci);
    wait_ov0(e);
    chk({nm, "_latency"}, 64'(e), 64'd4);
    chk({nm, "_s"}, 64'(s_v[0]), 64'(exp_s));
    chk({nm, "_co"}, 64'(co_v[0]), 64'(exp_co));
    cyc();
    chk({nm, "_ov_one_cycle"}, 64'(ov_v[0]), 64'd0);
  endtask

  task automatic rand_run(input int k);
    int          acc;
    int          budget;
    logic [31:0] m;
    acc    = 0;
    budget = 0;
    m      = msk(k);
    while (acc < 1000 && budget < 30000) begin
      iv_v[k]   = ($urandom_range(0, 1) == 1);
      a_v[k]    = $urandom & m;
      b_v[k]    = $urandom & m;
      ci_v[k]   = ($urandom_range(0, 1) == 1);
      ordy_v[k] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        a_v[k] = m;
        b_v[k] = ($urandom_range(0, 1) == 1) ? m : 32'd1;
      end
      if (iv_v[k] && ir_v[k]) acc++;
      cyc();
      budget++;
    end
    chk($sformatf("rand_w%0d_accepted", wid(k)), 64'(acc), 64'd1000);
    iv_v[k]   = 1'b0;
    ordy_v[k] = 1'b1;
    repeat (12) cyc();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_v[k] = 32'd0; b_v[k] = 32'd0; ci_v[k] = 1'b0;
      iv_v[k] = 1'b0; ordy_v[k] = 1'b1;
    end
    repeat (2) cyc();
    chk("reset_s",    64'(s_v[0]),  64'd0);
    chk("reset_co",   64'(co_v[0]), 64'd0);
    chk("reset_ov",   64'(ov_v[0]), 64'd0);
    chk("reset_busy", 64'(bz_v[0]), 64'd0);
    rst = 1'b0;
    cyc();
    chk("post_reset_in_ready", 64'(ir_v[0]), 64'd1);

    run0(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
    run0(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "carry_chain");
    run0(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "all_ones_ci");
    run0(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "zero_no_leak");

    // Backpressure: result held for three cycles, stray in_valid ignored.
    ordy_v[0] = 1'b0;
    accept0(16'h1234, 16'h4321, 1'b0);
    wait_ov0(e);
    chk("bp_latency", 64'(e), 64'd4);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_s",        64'(s_v[0]),  64'h5555);
      chk("bp_hold_co",       64'(co_v[0]), 64'd0);
      chk("bp_hold_ov",       64'(ov_v[0]), 64'd1);
      chk("bp_hold_in_ready", 64'(ir_v[0]), 64'd0);
      iv_v[0] = (i == 1);
      a_v[0]  = 32'h0000_FFFF;
      b_v[0]  = 32'h0000_0001;
      cyc();
    end
    iv_v[0] = 1'b0;
    chk("bp_still_held", 64'(s_v[0]), 64'h5555);
    ordy_v[0] = 1'b1;
    cyc();
    chk("bp_release_ov", 64'(ov_v[0]), 64'd0);
    chk("bp_release_ir", 64'(ir_v[0]), 64'd1);
    cyc();
    chk("bp_stray_ignored_busy", 64'(bz_v[0]), 64'd0);
    chk("bp_last_result_kept",   64'(s_v[0]),  64'h5555);

    // Reset during the second ADD cycle discards everything.
    accept0(16'hAAAA, 16'h1111, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_ov",   64'(ov_v[0]), 64'd0);
    chk("midrst_s",    64'(s_v[0]),  64'd0);
    chk("midrst_co",   64'(co_v[0]), 64'd0);
    chk("midrst_busy", 64'(bz_v[0]), 64'd0);
    rst = 1'b0;
    cyc();
    run0(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, "after_reset");

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
